// File: rtl/key_sched_pkg.sv
// Shared defaults and types for the key event scheduler and its event queue.
package key_sched_pkg;

    localparam int NUM_KEYS_DEFAULT   = 8;
    localparam int SAMPLE_DIV_DEFAULT = 32;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef logic [$clog2(NUM_KEYS_DEFAULT)-1:0] key_idx_t;

    // Increment with wrap for ranges that need not be a power of two.
    function automatic int wrap_inc(input int value, input int range);
        return (value + 1 >= range) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Key event queue: power-of-two depth, no bypass, head forced to zero while empty.
module key_evt_fifo
    import key_sched_pkg::*;
#(
    parameter int  DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter type data_t = key_idx_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  data_t                      push_data,
    input  logic                       pop,
    output data_t                      head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    data_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // NOTE: the storage array has no reset; stale contents are never observable
    // because the head is forced to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop updates from
    // the values present before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = empty ? data_t'('0) : mem[rd_ptr];

endmodule

// File: rtl/key_event_scheduler.sv
// Samples raw keys on a divided tick, turns new presses into pending requests and
// queues them round-robin into a small event FIFO, flagging presses that get merged.
module key_event_scheduler
    import key_sched_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DEFAULT,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         keyN,
    input  logic                        evt_ready,
    input  logic                        ovf_clr,
    output logic                        evt_valid,
    output logic [$clog2(NUM_KEYS)-1:0] evt_key,
    output logic                        sample_tick,
    output logic                        overflow
);

    localparam int IDX_W = $clog2(NUM_KEYS);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [NUM_KEYS-1:0] ONE_HOT0 = NUM_KEYS'(1);

    typedef logic [IDX_W-1:0] idx_t;

    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync_keyN;
    logic [DIV_W-1:0]    div_cnt;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] pending;
    idx_t                rr_ptr;

    logic [NUM_KEYS-1:0] new_press;
    logic [NUM_KEYS-1:0] grant_mask;
    logic                grant_found;
    idx_t                grant_idx;
    logic                grant;
    logic                pop;
    logic                ovf_set;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count_unused;

    // Released (1) is the safe reset value so no press is seen on reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '1;
            sync_keyN <= '1;
        end else begin
            sync_meta <= keyN;
            sync_keyN <= sync_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign sample_tick = (div_cnt == DIV_LAST);
    assign new_press   = sample_tick ? (~sync_keyN & ~pressed) : '0;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off < NUM_KEYS; off++) begin
            cand = int'(rr_ptr) + off;
            if (cand >= NUM_KEYS) begin
                cand = cand - NUM_KEYS;
            end
            if (!grant_found && pending[idx_t'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = idx_t'(cand);
            end
        end
    end

    assign pop        = evt_valid && evt_ready;
    assign grant      = grant_found && (!fifo_full || pop);
    assign grant_mask = grant ? (ONE_HOT0 << grant_idx) : '0;

    // A fresh press on a key still waiting (and not leaving this cycle) is merged and flagged.
    assign ovf_set = |(new_press & pending & ~grant_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pressed <= '0;
            pending <= '0;
            rr_ptr  <= '0;
        end else begin
            if (sample_tick) begin
                pressed <= ~sync_keyN;
            end
            pending <= (pending & ~grant_mask) | new_press;
            if (grant) begin
                rr_ptr <= idx_t'(wrap_inc(int'(grant_idx), NUM_KEYS));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    key_evt_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .data_t (idx_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant),
        .push_data (grant_idx),
        .pop       (pop),
        .head      (evt_key),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count_unused)
    );

    assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed and randomized checks of key_event_scheduler against a queue-based model.
module tb_key_event_scheduler;

    localparam int NK = 8;
    localparam int SD = 32;
    localparam int FD = 4;

    logic          clk;
    logic          reset;
    logic [NK-1:0] keyN;
    logic          evt_ready;
    logic          ovf_clr;
    logic          evt_valid;
    logic [2:0]    evt_key;
    logic          sample_tick;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model: key state as bit vectors, event queue as an int queue.
    logic [NK-1:0] m_s1, m_s2, m_pressed, m_pending;
    int            m_cnt, m_rr;
    bit            m_ovf;
    int            m_q[$];
    int            popped[$];
    int            popped_cyc[$];

    key_event_scheduler #(.NUM_KEYS(NK), .SAMPLE_DIV(SD), .FIFO_DEPTH(FD)) dut (
        .clk         (clk),
        .reset       (reset),
        .keyN        (keyN),
        .evt_ready   (evt_ready),
        .ovf_clr     (ovf_clr),
        .evt_valid   (evt_valid),
        .evt_key     (evt_key),
        .sample_tick (sample_tick),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_pressed = '0; m_pending = '0;
        m_cnt = 0; m_rr = 0; m_ovf = 1'b0;
        m_q.delete();
    endtask

    // Compares outputs for the current cycle, then advances DUT and model one clock.
    task automatic cycle();
        bit            tick, pop, set_ovf;
        int            g, k;
        logic [NK-1:0] newp, gmask, keys_now;
        check("evt_valid", evt_valid, (m_q.size() > 0));
        check("evt_key", evt_key, (m_q.size() > 0) ? m_q[0] : 0);
        check("sample_tick", sample_tick, (m_cnt == SD - 1));
        check("overflow", overflow, m_ovf);
        tick = (m_cnt == SD - 1);
        pop  = (m_q.size() > 0) && evt_ready;
        newp = tick ? (~m_s2 & ~m_pressed) : '0;
        g = -1;
        for (int off = 0; off < NK; off++) begin
            k = (m_rr + off) % NK;
            if (g < 0 && m_pending[k]) g = k;
        end
        if (g >= 0 && !(m_q.size() < FD || pop)) g = -1;
        gmask   = (g >= 0) ? (NK'(1) << g) : '0;
        set_ovf = |(newp & m_pending & ~gmask);
        keys_now = keyN;
        @(posedge clk);
        if (tick) m_pressed = ~m_s2;
        m_s2 = m_s1;
        m_s1 = keys_now;
        m_pending = (m_pending & ~gmask) | newp;
        m_cnt = (m_cnt + 1) % SD;
        if (pop) begin
            popped.push_back(m_q[0]);
            popped_cyc.push_back(cyc);
            void'(m_q.pop_front());
        end
        if (g >= 0) begin
            m_q.push_back(g);
            m_rr = (g + 1) % NK;
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Runs through the next tick cycle; returns positioned on the cycle after it.
    task automatic run_to_tick();
        bit t;
        for (int i = 0; i < SD; i++) begin
            t = (m_cnt == SD - 1);
            cycle();
            if (t) break;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        reset = 1'b1; keyN = 8'hF7; evt_ready = 1'b1; ovf_clr = 1'b0;
        model_reset();
        #1;
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_key", evt_key, 0);
        check("rst_sample_tick", sample_tick, 0);
        check("rst_overflow", overflow, 0);

        // Key 3 held from cycle 0: first tick at 31, event at 33, no repeat while held.
        do_reset();
        popped.delete();
        for (int i = 0; i < 34; i++) begin
            if (cyc == 30) check("a_no_tick_c30", sample_tick, 0);
            if (cyc == 31) check("a_tick_c31", sample_tick, 1);
            if (cyc == 33) begin
                check("a_valid_c33", evt_valid, 1);
                check("a_key_c33", evt_key, 3);
            end
            cycle();
        end
        run(10 * SD);
        check("a_held_single_event", popped.size(), 1);

        // Keys 1,5,6 on one tick with ready high: back-to-back events, then rr at 7.
        keyN = 8'hFF;
        do_reset();
        keyN = 8'h9D;
        popped.delete(); popped_cyc.delete();
        run(40);
        check("b_count", popped.size(), 3);
        check("b_first", popped[0], 1);
        check("b_second", popped[1], 5);
        check("b_third", popped[2], 6);
        check("b_consecutive", popped_cyc[2] - popped_cyc[0], 2);
        keyN = 8'hFF;
        run_to_tick();
        keyN = 8'h7E;
        popped.delete();
        run_to_tick();
        run(4);
        check("b_rr_first_7", popped[0], 7);
        check("b_rr_then_0", popped[1], 0);

        // Five keys with ready low: four queued, fifth waits and enters on the first pop.
        keyN = 8'hFF; evt_ready = 1'b0;
        do_reset();
        keyN = 8'hE0;
        run(40);
        check("c_full_valid", evt_valid, 1);
        check("c_full_head", evt_key, 0);
        popped.delete();
        evt_ready = 1'b1;
        cycle();
        evt_ready = 1'b0;
        check("c_after_pop_head", evt_key, 1);
        run(3);
        check("c_head_stable", evt_key, 1);
        evt_ready = 1'b1;
        run(6);
        evt_ready = 1'b0;
        check("c_drained", popped.size(), 5);
        check("c_last_is_4", popped[4], 4);

        // Queue full, key 2 pending, released then pressed again: merged press sets overflow.
        keyN = 8'hFF;
        do_reset();
        keyN = 8'hE4;
        run_to_tick();
        run(6);
        keyN = 8'hFF;
        run_to_tick();
        keyN = 8'hFB;
        run_to_tick();
        check("d_pending_no_ovf", overflow, 0);
        keyN = 8'hFF;
        run_to_tick();
        keyN = 8'hFB;
        run_to_tick();
        check("d_ovf_set", overflow, 1);
        run(3);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check("d_ovf_cleared", overflow, 0);

        // Asynchronous reset with three events queued discards everything.
        keyN = 8'hFF;
        do_reset();
        keyN = 8'hAB;
        run_to_tick();
        run(5);
        check("e_three_queued_valid", evt_valid, 1);
        keyN = 8'hFF;
        #2 reset = 1'b1;
        #1;
        check("e_async_valid_low", evt_valid, 0);
        check("e_async_key_zero", evt_key, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        popped.delete();
        evt_ready = 1'b1;
        for (int i = 0; i < 3 * SD; i++) begin
            if (cyc == SD - 1) check("e_first_tick", sample_tick, 1);
            cycle();
        end
        check("e_no_events", popped.size(), 0);

        // Push and pop coinciding at count 1.
        evt_ready = 1'b0;
        do_reset();
        keyN = 8'hDF;
        run_to_tick();
        run(3);
        keyN = 8'hBF;
        popped.delete();
        run_to_tick();
        evt_ready = 1'b1;
        cycle();
        evt_ready = 1'b0;
        check("f_valid_after_swap", evt_valid, 1);
        check("f_key_after_swap", evt_key, 6);
        cycle();
        check("f_key_stable", evt_key, 6);
        evt_ready = 1'b1;
        cycle();
        evt_ready = 1'b0;
        check("f_empty", evt_valid, 0);
        check("f_order", popped.size(), 2);
        check("f_popped_5", popped[0], 5);

        // Randomized traffic against the model.
        keyN = 8'hFF;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) keyN[$urandom_range(0, NK - 1)] ^= 1'b1;
            evt_ready = ($urandom_range(0, 9) < 3);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_event_scheduler.md
KEY_EVENT_SCHEDULER -- requirements
Module: key_event_scheduler

Interface
REQ-001 Parameter NUM_KEYS SHALL default 8; number of raw key inputs.
REQ-002 Parameter SAMPLE_DIV SHALL default 32; clocks per key sampling period.
REQ-003 Parameter FIFO_DEPTH SHALL default 4; event queue entries, power of two.
REQ-004 Port clk, input, 1: the single clock; all state on rising edge.
REQ-005 Port reset, input, 1: reset is asynchronous and active-high.
REQ-006 Port keyN, input, NUM_KEYS: raw asynchronous keys, 0 = pressed.
REQ-007 Port evt_ready, input, 1: consumer accepts the head event.
REQ-008 Port ovf_clr, input, 1: clears the overflow flag.
REQ-009 Port evt_valid, output, 1: queue head is valid.
REQ-010 Port evt_key, output, $clog2(NUM_KEYS): index of the key at queue head.
REQ-011 Port sample_tick, output, 1: one-clock strobe marking each sampling instant.
REQ-012 Port overflow, output, 1: sticky lost-press flag.

Function
REQ-013 keyN SHALL pass a 2-flop synchronizer per bit before any use.
REQ-014 Divider counter SHALL count 0..SAMPLE_DIV-1, wrap to 0; sample_tick = 1 exactly in cycles where counter == SAMPLE_DIV-1.
REQ-015 On a tick edge: pressed <= ~sync_keyN; pending |= ~sync_keyN & ~pressed (new press only); held keys SHALL NOT re-trigger.
REQ-016 Releases SHALL update pressed only; no event.
REQ-017 Arbiter SHALL grant at most one pending key per cycle: lowest index >= rr_ptr, wrapping to 0.
REQ-018 Grant SHALL occur only if queue not full, or a pop happens in the same cycle.
REQ-019 Grant SHALL push the index into the FIFO, clear that pending bit, and set rr_ptr = (granted+1) mod NUM_KEYS.
REQ-020 If a tick sets a pending bit being cleared by a grant in the same cycle, set SHALL win; no overflow.
REQ-021 If a tick detects a new press for a key whose pending bit is already set and not granted that cycle, overflow SHALL be set; the press is merged.
REQ-022 ovf_clr SHALL clear overflow; a simultaneous set SHALL win.
REQ-023 Pop SHALL occur when evt_valid && evt_ready; evt_key SHALL hold stable while evt_valid && !evt_ready.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged and work at full and at empty+push (no bypass).
REQ-025 Latency: sole new press, empty queue: pending visible 1 clk after tick edge; evt_valid rises 2 clk after tick edge.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Reset
REQ-027 While reset is high, SHALL hold: synchronizers = all 1 (released); pressed = 0; pending = 0; counter = 0; rr_ptr = 0; FIFO empty.
REQ-028 Reset outputs SHALL be: evt_valid = 0, evt_key = 0, sample_tick = 0, overflow = 0.
REQ-029 Reset mid-operation SHALL discard all queued and pending events; the first tick after release SHALL occur at cycle SAMPLE_DIV-1.

Structure
REQ-030 Package key_sched_pkg SHALL hold defaults NUM_KEYS, SAMPLE_DIV, FIFO_DEPTH, and typedef key_idx_t (logic [$clog2(NUM_KEYS)-1:0]).
REQ-031 The queue SHALL be one sub-module, key_evt_fifo (push/pop/full/empty/count, key_idx_t data); the synchronizer, divider, and arbiter stay in the top.

Verification
REQ-032 Reset, keyN[3]=0 held from cycle 0: sample_tick in cycle 31, evt_valid=1 with evt_key=3 at cycle 33; held key gives no second event over 10 ticks.
REQ-033 keyN[1], [5], [6] pressed before the same tick, evt_ready=1, rr_ptr=0: events 1, 5, 6 on consecutive cycles; then rr_ptr=7.
REQ-034 evt_ready=0, 5 distinct keys pressed on one tick: 4 queued (keys 0..3), key 4 stays pending; first pop enqueues key 4 the same cycle; count stays 4.
REQ-035 evt_ready=0, queue full, key 2 pending, key 2 released then re-pressed on the next tick: overflow=1; ovf_clr pulse -> overflow=0.
REQ-036 Reset asserted asynchronously mid-cycle with 3 events queued: evt_valid=0 immediately; no events after release until a new press.
REQ-037 Push and pop coincide at count 4 and at count 1: count stays 4 and 1; order preserved.
